// File: rtl/stack_engine.sv
// Stack controller: PUSH/POP/CALL/RET over a req/ack memory port.
// Returns the updated stack pointer as a one-cycle write pulse.
module stack_engine #(
   parameter logic [31:0] SP_TOP   = 32'd16,
   parameter logic [31:0] SP_LIMIT = 32'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] sp_in,
   input  logic [31:0] push_data,
   input  logic [31:0] ret_addr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] sp_out,
   output logic        sp_write,
   output logic [31:0] pop_data,
   output logic        pc_load,
   output logic        busy,
   output logic        done,
   output logic        fault
);

   localparam logic [1:0] OP_PUSH = 2'b00;
   localparam logic [1:0] OP_POP  = 2'b01;
   localparam logic [1:0] OP_CALL = 2'b10;
   localparam logic [1:0] OP_RET  = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      FINISH,
      FAULT
   } stateT;

   stateT       state;
   stateT       stateNext;
   logic [1:0]  opQ;
   logic [31:0] spNew;
   logic        isWrite;
   logic        startFault;
   logic        accept;
   logic        ackTaken;
   logic        opQWrite;

   // decode the incoming request and pick the next controller state
   always_comb begin
      stateNext  = state;
      isWrite    = (op == OP_PUSH) || (op == OP_CALL);
      startFault = isWrite ? (sp_in == SP_LIMIT)
                           : (sp_in >= SP_TOP);
      opQWrite   = (opQ == OP_PUSH) || (opQ == OP_CALL);
      accept     = 1'b0;
      ackTaken   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept    = ~startFault;
               stateNext = startFault ? FAULT : ACCESS;
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               ackTaken  = 1'b1;
               stateNext = FINISH;
            end
         end
         FINISH:  stateNext = IDLE;
         FAULT:   stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // controller state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // registered outputs and latched transfer context
   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         done      <= 1'b0;
         sp_write  <= 1'b0;
         fault     <= 1'b0;
         pc_load   <= 1'b0;
         pop_data  <= '0;
         sp_out    <= SP_TOP;
         opQ       <= OP_PUSH;
         spNew     <= SP_TOP;
      end else begin
         busy     <= stateNext != IDLE;
         mem_req  <= stateNext == ACCESS;
         done     <= (stateNext == FINISH) ||
                     (stateNext == FAULT);
         sp_write <= stateNext == FINISH;
         fault    <= stateNext == FAULT;
         pc_load  <= (stateNext == FINISH) &&
                     (opQ == OP_RET);
         if (accept) begin
            opQ      <= op;
            mem_we   <= isWrite;
            mem_addr <= isWrite ? sp_in - 32'd1 : sp_in;
            spNew    <= isWrite ? sp_in - 32'd1
                                : sp_in + 32'd1;
            if (op == OP_CALL)
               mem_wdata <= ret_addr;
            else if (op == OP_PUSH)
               mem_wdata <= push_data;
            else
               mem_wdata <= '0;
         end
         if (ackTaken) begin
            mem_we <= 1'b0;
            sp_out <= spNew;
            if (!opQWrite)
               pop_data <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_stack_engine.sv
// Directed bench for stack_engine with a transaction-level model
// and a small word memory that answers the req/ack port.
module tb_stack_engine;

   localparam logic [31:0] TOP = 32'd16;
   localparam logic [31:0] LIM = 32'd0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] sp_in = '0;
   logic [31:0] push_data = '0;
   logic [31:0] ret_addr = '0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack;
   logic [31:0] sp_out;
   logic        sp_write;
   logic [31:0] pop_data;
   logic        pc_load;
   logic        busy;
   logic        done;
   logic        fault;

   logic        autoAck = 1'b0;
   logic        spurAck = 1'b0;
   assign mem_ack = autoAck | spurAck;

   stack_engine #(.SP_TOP(TOP), .SP_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .sp_in(sp_in), .push_data(push_data),
      .ret_addr(ret_addr), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .sp_out(sp_out),
      .sp_write(sp_write), .pop_data(pop_data),
      .pc_load(pc_load), .busy(busy), .done(done),
      .fault(fault)
   );

   always #5 clk = ~clk;

   int vecCnt = 0;
   int errCnt = 0;
   bit armed = 1'b0;

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      vecCnt++;
      if (act !== exp) begin
         errCnt++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // memory responder: acks after ackDelay request cycles
   logic [31:0] memArr [0:31];
   int  ackDelay = 0;
   int  waitCnt = 0;
   bit  ackGiven = 1'b0;
   int  txCnt = 0;

   initial for (int i = 0; i < 32; i++) memArr[i] = '0;

   always @(negedge clk) begin
      autoAck = 1'b0;
      if (mem_req === 1'b1 && !ackGiven) begin
         if (waitCnt >= ackDelay) begin
            autoAck   = 1'b1;
            ackGiven  = 1'b1;
            mem_rdata = memArr[mem_addr[4:0]];
            if (mem_we) memArr[mem_addr[4:0]] = mem_wdata;
            txCnt++;
         end else begin
            waitCnt++;
         end
      end else if (mem_req !== 1'b1) begin
         waitCnt  = 0;
         ackGiven = 1'b0;
      end
   end

   // transaction-level model of what the outputs must be
   logic        eBusy, eReq, eWe, eDone, eSpW, eFault, ePc;
   logic [31:0] eAddr, eWdata, ePop, eSp, tSp;
   logic [1:0]  tOp;

   always @(posedge clk) begin
      logic wr, bad, wasReq, wasBusy;
      if (rst) begin
         eBusy = 0; eReq = 0; eWe = 0; eDone = 0;
         eSpW = 0; eFault = 0; ePc = 0;
         eAddr = 0; eWdata = 0; ePop = 0; eSp = TOP;
         tSp = 0; tOp = 0;
      end else begin
         wasReq  = eReq;
         wasBusy = eBusy;
         eDone = 0; eSpW = 0; eFault = 0; ePc = 0;
         if (!wasBusy) begin
            if (start) begin
               eBusy = 1;
               wr  = (op == 2'b00) || (op == 2'b10);
               bad = wr ? (sp_in == LIM) : (sp_in >= TOP);
               if (bad) begin
                  eDone = 1; eFault = 1;
               end else begin
                  eReq = 1; eWe = wr;
                  eAddr = wr ? sp_in - 1 : sp_in;
                  eWdata = (op == 2'b10) ? ret_addr : push_data;
                  tOp = op; tSp = sp_in;
               end
            end
         end else if (wasReq) begin
            if (mem_ack) begin
               eReq = 0; eDone = 1; eSpW = 1;
               ePc = (tOp == 2'b11);
               if (tOp == 2'b00 || tOp == 2'b10) begin
                  eSp = tSp - 1;
               end else begin
                  eSp = tSp + 1;
                  ePop = mem_rdata;
               end
            end
         end else begin
            eBusy = 0;
         end
      end
   end

   int doneCnt = 0;
   int swCnt = 0;

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (armed) begin
         check("busy", busy, eBusy);
         check("mem_req", mem_req, eReq);
         check("done", done, eDone);
         check("sp_write", sp_write, eSpW);
         check("fault", fault, eFault);
         check("pc_load", pc_load, ePc);
         check("pop_data", pop_data, ePop);
         check("sp_out", sp_out, eSp);
         if (eReq) begin
            check("mem_we", mem_we, eWe);
            check("mem_addr", mem_addr, eAddr);
            if (eWe) check("mem_wdata", mem_wdata, eWdata);
         end
         if (done === 1'b1) doneCnt++;
         if (sp_write === 1'b1) swCnt++;
      end
   end

   int          rCyc;
   logic        rReq, rWe, rSw, rPc, rFlt;
   logic [31:0] rAddr, rWdata, rSpo, rPop;

   task automatic runOp(input logic [1:0] o,
                        input logic [31:0] sp,
                        input logic [31:0] pd,
                        input logic [31:0] ra,
                        input int dly,
                        input bit hold);
      @(negedge clk);
      ackDelay = dly;
      start = 1; op = o; sp_in = sp;
      push_data = pd; ret_addr = ra;
      rCyc = 0; rReq = 0; rWe = 0; rSw = 0; rPc = 0;
      rFlt = 0; rAddr = 0; rWdata = 0; rSpo = 0; rPop = 0;
      do begin
         @(negedge clk);
         rCyc++;
         if (!hold) start = 0;
         if (mem_req) begin
            rReq = 1; rWe = mem_we;
            rAddr = mem_addr; rWdata = mem_wdata;
         end
         if (done) begin
            start = 0;
            rSw = sp_write; rPc = pc_load; rFlt = fault;
            rSpo = sp_out; rPop = pop_data;
         end
      end while (busy && rCyc < 60);
      start = 0;
      if (rCyc >= 60) check("op_timeout", 32'(rCyc), 32'd0);
   endtask

   initial begin
      int tx0, d0, s0;
      repeat (3) @(negedge clk);
      rst = 0;
      armed = 1;
      @(negedge clk);
      check("rst_sp_out", sp_out, 32'd16);
      check("rst_busy", busy, 32'd0);
      check("rst_req", mem_req, 32'd0);

      d0 = doneCnt;
      runOp(2'b00, 32'd16, 32'hAA, 32'd0, 2, 0);
      check("push_addr", rAddr, 32'd15);
      check("push_we", rWe, 32'd1);
      check("push_wdata", rWdata, 32'hAA);
      check("push_sp", rSpo, 32'd15);
      check("push_sw", rSw, 32'd1);
      check("push_dones", 32'(doneCnt - d0), 32'd1);

      runOp(2'b01, 32'd15, 32'd0, 32'd0, 0, 0);
      check("pop_data", rPop, 32'hAA);
      check("pop_sp", rSpo, 32'd16);
      check("pop_pc", rPc, 32'd0);
      check("pop_cycles", 32'(rCyc), 32'd3);

      runOp(2'b10, 32'd16, 32'd0, 32'h40, 1, 0);
      check("call_addr", rAddr, 32'd15);
      check("call_wdata", rWdata, 32'h40);
      check("call_mem", memArr[15], 32'h40);

      runOp(2'b11, 32'd15, 32'd0, 32'd0, 0, 0);
      check("ret_pc", rPc, 32'd1);
      check("ret_pop", rPop, 32'h40);
      check("ret_sp", rSpo, 32'd16);

      runOp(2'b01, 32'd16, 32'd0, 32'd0, 0, 0);
      check("uflow_fault", rFlt, 32'd1);
      check("uflow_req", rReq, 32'd0);
      check("uflow_sw", rSw, 32'd0);
      check("uflow_cyc", 32'(rCyc), 32'd2);
      check("uflow_pop", rPop, 32'h40);

      runOp(2'b00, 32'd0, 32'h77, 32'd0, 0, 0);
      check("oflow_fault", rFlt, 32'd1);
      check("oflow_req", rReq, 32'd0);
      check("oflow_sw", rSw, 32'd0);

      tx0 = txCnt; d0 = doneCnt;
      runOp(2'b00, 32'd16, 32'h55, 32'd0, 5, 1);
      check("hold_tx", 32'(txCnt - tx0), 32'd1);
      check("hold_dones", 32'(doneCnt - d0), 32'd1);
      check("hold_mem", memArr[15], 32'h55);

      spurAck = 1;
      @(negedge clk);
      spurAck = 0;
      @(negedge clk);
      check("spur_busy", busy, 32'd0);
      check("spur_sp", sp_out, 32'd15);

      d0 = doneCnt; s0 = swCnt;
      ackDelay = 20;
      start = 1; op = 2'b00; sp_in = 32'd15;
      push_data = 32'h99;
      @(negedge clk);
      start = 0;
      @(negedge clk);
      check("mid_req", mem_req, 32'd1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("mid_req_drop", mem_req, 32'd0);
      check("mid_busy", busy, 32'd0);
      check("mid_sp", sp_out, 32'd16);
      repeat (6) @(negedge clk);
      check("mid_dones", 32'(doneCnt - d0), 32'd0);
      check("mid_sw", 32'(swCnt - s0), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vecCnt, errCnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/stack_engine.md
# stack_engine

Multi-cycle stack controller sitting directly upstream of the register bank's stack-pointer write port. It samples the current stack pointer, performs PUSH/POP/CALL/RET transfers to data memory over a req/ack handshake, and returns the updated pointer as a one-cycle SP write pulse. It also delivers popped data and return addresses to the processor datapath, and flags stack overflow and underflow without touching memory.

## Interface
- SP_TOP, 16: empty-stack pointer value; the register-bank reset value of SP.
- SP_LIMIT, 0: lowest legal pointer value. A push that would go below it faults.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  launches an operation. Sampled only in IDLE.
- op  in  2  operation: 00 PUSH, 01 POP, 10 CALL, 11 RET. Sampled with start.
- sp_in  in  32  current SP from the register bank. Sampled with start.
- push_data  in  32  PUSH payload. Sampled with start.
- ret_addr  in  32  CALL link address (PC+1). Sampled with start.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write (PUSH/CALL), 0 = read (POP/RET).
- mem_addr  out  32  word address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data; valid in the mem_ack cycle.
- mem_ack  in  1  memory completion, one cycle.
- sp_out  out  32  new SP value; drives WriteDataSP.
- sp_write  out  1  one-cycle pulse; drives SPWrite.
- pop_data  out  32  value read by POP/RET. Holds until the next POP/RET completes.
- pc_load  out  1  one-cycle pulse with done on a successful RET; pop_data is the target PC.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- fault  out  1  one-cycle pulse with done on overflow or underflow.

## Operation
- Stack is full-descending and word-addressed. SP points at the top element; SP == SP_TOP means empty.
- PUSH/CALL:
  - mem_addr = sp_in-1; mem_wdata = push_data (PUSH) or ret_addr (CALL).
  - On completion, sp_out = sp_in-1.
- POP/RET:
  - mem_addr = sp_in.
  - On completion, pop_data = mem_rdata and sp_out = sp_in+1.
- Faults:
  - Overflow: PUSH/CALL with sp_in == SP_LIMIT.
  - Underflow: POP/RET with sp_in >= SP_TOP.
  - A faulting operation issues no memory request and no sp_write; pop_data is unchanged.
- Arithmetic is 32-bit unsigned. Overflow is detected before decrement, so SP never wraps.
- FSM states: IDLE, ACCESS, FINISH, FAULT.
  - IDLE: on start, latch op, sp_in and data. Go to FAULT if the fault condition holds, else ACCESS.
  - ACCESS: mem_req=1 with stable addr/we/wdata. On mem_ack, capture rdata and go to FINISH.
  - FINISH: sp_write=1, done=1, pc_load=1 if op was RET; return to IDLE.
  - FAULT: done=1, fault=1; return to IDLE.
- start is ignored while busy; no queuing.
- All outputs are registered.

## Timing
- Reset values:
  - mem_req, mem_we, sp_write, done, fault, pc_load, busy = 0.
  - mem_addr, mem_wdata, pop_data = 0.
  - sp_out = SP_TOP.
  - State = IDLE.
- Success path: start at edge 0 → mem_req high from cycle 1. mem_ack in cycle k (k≥1) → done/sp_write in cycle k+1 → busy low in cycle k+2. Minimum 3 cycles start-to-IDLE.
- Fault path: start at edge 0 → done/fault in cycle 1 → IDLE in cycle 2.
- mem_req deasserts the cycle after mem_ack. mem_ack outside ACCESS is ignored.
- A start that coincides with done is ignored (state is not IDLE). The next start is accepted in the cycle after busy falls.
- rst mid-operation: state returns to IDLE on that edge and mem_req drops. No sp_write/done is produced. A pending ack is discarded.

## Test plan
- Reset, then PUSH push_data=0xAA, sp_in=16, ack after 2 cycles → mem_we=1, mem_addr=15, mem_wdata=0xAA; sp_write pulse with sp_out=15; done one cycle.
- POP sp_in=15, mem_rdata=0xAA with immediate ack → pop_data=0xAA, sp_out=16, pc_load=0; start-to-IDLE 3 cycles.
- CALL ret_addr=0x40 at sp_in=16, then RET at sp_in=15 returning 0x40 → CALL writes 0x40 to address 15; RET gives pc_load=1 with pop_data=0x40 and sp_out=16.
- POP at sp_in=16 and PUSH at sp_in=0 → fault+done in cycle 1; mem_req never asserted; sp_write=0; pop_data unchanged.
- start held high during a PUSH with ack delayed 5 cycles → exactly one memory transaction and one done pulse. A spurious mem_ack while IDLE has no effect.
- rst asserted while mem_req=1 → next cycle mem_req=0, busy=0, sp_out=16. No sp_write or done appears afterwards.
